// File: rtl/ecc_pkg.sv
// Shared constants and types for the P1 point read-out engine.
// Word geometry, default field prime and the read-out FSM encoding.
package ecc_pkg;

    localparam int WORD_W = 32;
    localparam int PT_W   = 256;
    localparam int NWORDS = PT_W / WORD_W;

    localparam logic [PT_W-1:0] P_MOD_DEFAULT =
        256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;

    typedef logic [NWORDS-1:0][WORD_W-1:0] word_vec_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SUB_X = 3'd1,
        OUT_X = 3'd2,
        SUB_Y = 3'd3,
        OUT_Y = 3'd4,
        DONE  = 3'd5
    } rd_state_e;

endpackage

// File: rtl/ecc_word_addsub.sv
// One word of a multi-word add or subtract; cout is the carry (add) or borrow (sub) out.
module ecc_word_addsub
    import ecc_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              sub,
    input  logic              cin,
    output logic [WORD_W-1:0] res,
    output logic              cout
);

    logic [WORD_W:0] ext;

    // Zero-extended subtract sets the top bit exactly when a < b + cin.
    always_comb begin
        ext = '0;
        if (sub) begin
            ext = {1'b0, a} - {1'b0, b} - {{WORD_W{1'b0}}, cin};
        end else begin
            ext = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, cin};
        end
    end

    assign res  = ext[WORD_W-1:0];
    assign cout = ext[WORD_W];

endmodule

// File: rtl/ecc_p1_rdout.sv
// P1 read-out engine: snapshots (xp,xn,yp,yn), reduces x then y word-serially and streams 16 words.
// Build option ECC_RDOUT_PARITY_EN adds a registered even-parity output out_par.
module ecc_p1_rdout
    import ecc_pkg::*;
#(
    parameter logic [PT_W-1:0] P_MOD = P_MOD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_start,
    input  logic [PT_W-1:0]   ecp1_xp,
    input  logic [PT_W-1:0]   ecp1_xn,
    input  logic [PT_W-1:0]   ecp1_yp,
    input  logic [PT_W-1:0]   ecp1_yn,
    output logic              rd_busy,
    output logic              rd_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [3:0]        out_idx,
    output logic              out_last
`ifdef ECC_RDOUT_PARITY_EN
    ,
    output logic              out_par
`endif
);

    // Output port: a beat transfers on a rising edge where out_valid & out_ready;
    // while out_valid is high and out_ready low, every out_* register holds its value.

    localparam word_vec_t P_WORDS = P_MOD;

    rd_state_e state, state_nxt;

    word_vec_t snap_xp, snap_xn, snap_yp, snap_yn;
    word_vec_t rbuf;
    logic [2:0] wcnt;
    logic       phase;
    logic       neg;
    logic       cy;

    logic sub_step, load, last_hs;

    logic [WORD_W-1:0] as_a, as_b, as_res;
    logic              as_sub, as_cin, as_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sub_step  = 1'b0;
        load      = 1'b0;
        last_hs   = 1'b0;
        case (state)
            IDLE: begin
                if (rd_start) state_nxt = SUB_X;
            end
            SUB_X, SUB_Y: begin
                sub_step = 1'b1;
                if (wcnt == 3'd7) state_nxt = (state == SUB_X) ? OUT_X : OUT_Y;
            end
            OUT_X, OUT_Y: begin
                last_hs = out_valid & out_ready & (out_idx[2:0] == 3'd7);
                // Empty register on entry, or the current beat leaves and it was not word 7.
                load    = !out_valid | (out_ready & (out_idx[2:0] != 3'd7));
                if (last_hs) state_nxt = (state == OUT_X) ? SUB_Y : DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign rd_busy = (state != IDLE) && (state != DONE);
    assign rd_done = (state == DONE);

    // The single adder subtracts the snapshot in SUB and adds the prime correction in OUT.
    always_comb begin
        as_sub = sub_step;
        as_cin = (wcnt == 3'd0) ? 1'b0 : cy;
        as_a   = '0;
        as_b   = '0;
        if (sub_step) begin
            as_a = phase ? snap_yp[wcnt] : snap_xp[wcnt];
            as_b = phase ? snap_yn[wcnt] : snap_xn[wcnt];
        end else begin
            as_a = rbuf[wcnt];
            as_b = neg ? P_WORDS[wcnt] : '0;
        end
    end

    ecc_word_addsub u_addsub (
        .a    (as_a),
        .b    (as_b),
        .sub  (as_sub),
        .cin  (as_cin),
        .res  (as_res),
        .cout (as_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_xp   <= '0;
            snap_xn   <= '0;
            snap_yp   <= '0;
            snap_yn   <= '0;
            rbuf      <= '0;
            wcnt      <= '0;
            phase     <= 1'b0;
            neg       <= 1'b0;
            cy        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            if (state == IDLE && rd_start) begin
                snap_xp <= ecp1_xp;
                snap_xn <= ecp1_xn;
                snap_yp <= ecp1_yp;
                snap_yn <= ecp1_yn;
                wcnt    <= '0;
                phase   <= 1'b0;
                neg     <= 1'b0;
                cy      <= 1'b0;
            end
            if (sub_step) begin
                rbuf[wcnt] <= as_res;
                cy         <= as_cout;
                wcnt       <= wcnt + 3'd1;
                if (wcnt == 3'd7) neg <= as_cout;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= as_res;
                out_idx   <= {phase, wcnt};
                out_last  <= phase & (wcnt == 3'd7);
                cy        <= as_cout;
                wcnt      <= wcnt + 3'd1;
            end else if (last_hs) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                if (state == OUT_X) phase <= 1'b1;
            end
        end
    end

`ifdef ECC_RDOUT_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_par <= 1'b0;
        end else if (load) begin
            out_par <= ^as_res;
        end
    end
`endif

endmodule

// File: tb/tb_ecc_p1_rdout.sv
// Bench for ecc_p1_rdout: directed scenarios plus randomized transfers against a 256-bit arithmetic model.
module tb_ecc_p1_rdout;
  import ecc_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rd_start = 1'b0;
  logic         out_ready = 1'b0;
  logic [255:0] xp = '0, xn = '0, yp = '0, yn = '0;
  logic         rd_busy, rd_done, out_valid, out_last;
  logic [31:0]  out_data;
  logic [3:0]   out_idx;
`ifdef ECC_RDOUT_PARITY_EN
  logic         out_par;
`endif

  localparam logic [255:0] PM = P_MOD_DEFAULT;

  int n_checks = 0;
  int n_fail = 0;
  logic [36:0] exp_q[$];

  ecc_p1_rdout dut (
    .clk(clk), .rst_n(rst_n), .rd_start(rd_start),
    .ecp1_xp(xp), .ecp1_xn(xn), .ecp1_yp(yp), .ecp1_yn(yn),
    .rd_busy(rd_busy), .rd_done(rd_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
`ifdef ECC_RDOUT_PARITY_EN
    , .out_par(out_par)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] canon(input logic [255:0] p, input logic [255:0] n);
    logic [255:0] d;
    d = p - n;
    if (p < n) d = d + PM;
    return d;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // mode 0: always ready, 1: random ready, 2: stall 5 cycles on beat 3
  task automatic run_xfer(input logic [255:0] a, input logic [255:0] b,
                          input logic [255:0] c, input logic [255:0] d,
                          input int mode, input bit repulse, input string name);
    logic [255:0] x, y, v;
    logic [36:0]  obs, prev_obs, e;
    int n, first_valid, dones, done_at, beats, stall;
    bit prev_stall, r;
    x = canon(a, b);
    y = canon(c, d);
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      v = (i < 8) ? x : y;
      exp_q.push_back({(i == 15), 4'(i), v[32*(i%8) +: 32]});
    end
    first_valid = -1; dones = 0; done_at = -1; beats = 0; stall = 0; prev_stall = 0; prev_obs = '0;
    @(negedge clk);
    xp = a; xn = b; yp = c; yn = d;
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    xp = rand256(); xn = rand256(); yp = rand256(); yn = rand256();
    n = 0;
    while (n <= 400) begin
      obs = {out_last, out_idx, out_data};
      if (n == 0) begin
        n_checks++;
        if (rd_busy !== 1'b1) begin
          n_fail++; $display("FAIL %s busy_after_start: got %b expected 1", name, rd_busy);
        end
      end
      if (out_valid === 1'b1 && first_valid < 0) first_valid = n;
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || obs !== prev_obs) begin
          n_fail++; $display("FAIL %s hold: got v=%b %h expected v=1 %h", name, out_valid, obs, prev_obs);
        end
      end
      if (rd_done === 1'b1) begin
        dones++; done_at = n;
        n_checks++;
        if (rd_busy !== 1'b0 || out_valid !== 1'b0) begin
          n_fail++; $display("FAIL %s done_state: got busy=%b valid=%b expected 0 0", name, rd_busy, out_valid);
        end
      end
      case (mode)
        0: r = 1'b1;
        1: r = ($urandom_range(0, 99) < 60);
        default: begin
          if (out_valid === 1'b1 && out_idx === 4'd3 && stall < 5) begin
            r = 1'b0; stall++;
          end else r = 1'b1;
        end
      endcase
      out_ready = r;
      if (repulse) rd_start = (n == 20);
      if (out_valid === 1'b1 && r) begin
        beats++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL %s extra_beat: got %h expected none", name, obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            n_fail++; $display("FAIL %s beat: got %h expected %h", name, obs, e);
          end
`ifdef ECC_RDOUT_PARITY_EN
          n_checks++;
          if (out_par !== ^e[31:0]) begin
            n_fail++; $display("FAIL %s parity: got %b expected %b", name, out_par, ^e[31:0]);
          end
`endif
        end
      end
      prev_stall = (out_valid === 1'b1) && !r;
      prev_obs = obs;
      if (dones > 0) break;
      @(negedge clk);
      n++;
    end
    rd_start = 1'b0;
    n_checks++;
    if (dones != 1) begin
      n_fail++; $display("FAIL %s done_timeout: got %0d done pulses expected 1", name, dones);
    end
    n_checks++;
    if (first_valid != 9) begin
      n_fail++; $display("FAIL %s first_valid_latency: got %0d expected 9", name, first_valid);
    end
    if (mode == 0) begin
      n_checks++;
      if (done_at != 34) begin
        n_fail++; $display("FAIL %s done_latency: got %0d expected 34", name, done_at);
      end
    end
    n_checks++;
    if (beats != 16 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL %s beat_count: got %0d (left %0d) expected 16 (left 0)", name, beats, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rd_busy, rd_done, out_valid, out_data, out_idx, out_last} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", {rd_busy, rd_done, out_valid, out_data, out_idx, out_last});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rd_busy, rd_done, out_valid, out_last} !== 4'b0) begin
      n_fail++; $display("FAIL idle_outputs: got %b expected 0000", {rd_busy, rd_done, out_valid, out_last});
    end
  endtask

  task automatic test_basic();
    run_xfer(256'd5, 256'd3, 256'h10, 256'd0, 0, 1'b0, "basic");
  endtask

  task automatic test_negative();
    run_xfer(256'd3, 256'd5, 256'd7, 256'd9, 0, 1'b0, "negative");
  endtask

  task automatic test_backpressure();
    run_xfer(rand256() % PM, rand256() % PM, rand256() % PM, rand256() % PM, 2, 1'b0, "backpressure");
  endtask

  task automatic test_restart_ignored();
    run_xfer(rand256() % PM, rand256() % PM, rand256() % PM, rand256() % PM, 0, 1'b1, "restart_ignored");
  endtask

  task automatic test_equal_max();
    run_xfer(PM - 1, PM - 1, PM - 1, PM - 1, 0, 1'b0, "equal_max");
  endtask

  task automatic test_reset_mid();
    int n;
    bit hit;
    hit = 0;
    @(negedge clk);
    xp = 256'd11; xn = 256'd99; yp = 256'd1; yn = 256'd2;
    rd_start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    for (n = 0; n < 100; n++) begin
      if (out_valid === 1'b1 && out_idx === 4'd4) begin
        hit = 1; break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!hit) begin
      n_fail++; $display("FAIL reset_mid_reach_beat4: got none expected beat 4 within 100 cycles");
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rd_busy, rd_done, out_valid, out_data, out_idx, out_last} !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %h expected 0", {rd_busy, rd_done, out_valid, out_data, out_idx, out_last});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_xfer(rand256() % PM, rand256() % PM, rand256() % PM, rand256() % PM, 0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      if (t % 5 == 4)
        run_xfer(rand256(), rand256(), rand256(), rand256(), 1, 1'b0, "random_raw");
      else
        run_xfer(rand256() % PM, rand256() % PM, rand256() % PM, rand256() % PM, 1, 1'b0, "random");
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 3; t++)
      run_xfer(rand256() % PM, rand256() % PM, rand256() % PM, rand256() % PM, 0, 1'b0, "back_to_back");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid();
    test_equal_max();
    test_random();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
